// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer. One full-adder cell processes the operands
// LSB first, one bit per clock, with the carry recirculated through a flop.

module serial_add_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             in_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);
    localparam int CW = $clog2(WIDTH);

    // state  | meaning
    // IDLE   | waiting for start; operands captured on the accepting edge
    // RUN    | one bit per cycle through the adder cell, LSB first
    // DONE   | one-cycle result-valid pulse, then back to IDLE
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_a_q;
    logic [WIDTH-1:0] shift_b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             carry_q;
    logic             cmsb_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic fa_s;
    logic fa_c;
    logic last_bit;
    logic msb_in_bit;

    serial_add_fa u_fa (
        .a_i (shift_a_q[0]),
        .b_i (shift_b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    assign res_d      = {fa_s, res_q[WIDTH-1:1]};
    assign cnt_d      = cnt_q + CW'(1);
    assign last_bit   = (cnt_q == CW'(WIDTH - 1));
    assign msb_in_bit = (cnt_q == CW'(WIDTH - 2));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            cmsb_q    <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        // Subtract as A + ~B + 1; cin is ignored for subtract.
                        shift_a_q <= a_i;
                        shift_b_q <= sub_i ? ~b_i : b_i;
                        carry_q   <= sub_i ? 1'b1 : cin_i;
                        cnt_q     <= '0;
                        res_q     <= '0;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    shift_a_q <= shift_a_q >> 1;
                    shift_b_q <= shift_b_q >> 1;
                    res_q     <= res_d;
                    carry_q   <= fa_c;
                    cnt_q     <= cnt_d;
                    // Carry out of bit WIDTH-2 is the carry into the MSB.
                    if (msb_in_bit) begin
                        cmsb_q <= fa_c;
                    end
                    if (last_bit) begin
                        sum_q   <= res_d;
                        cout_q  <= fa_c;
                        ovf_q   <= cmsb_q ^ fa_c;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o = (state_q == S_IDLE);
    assign busy_o     = (state_q == S_RUN) || (state_q == S_DONE);
    assign done_o     = (state_q == S_DONE);
    assign sum_o      = sum_q;
    assign cout_o     = cout_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and streaming checks for serial_add_seq at WIDTH=8.

module tb_serial_add_seq;
    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic         sub_i;
    logic         cin_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         in_ready_o;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         ovf_o;

    int n_tests = 0;
    int n_fail  = 0;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .sub_i      (sub_i),
        .cin_i      (cin_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .in_ready_o (in_ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .sum_o      (sum_o),
        .cout_o     (cout_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Returns {cout, ovf, sum} computed arithmetically.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub, input logic cin);
        logic [W-1:0] bb;
        logic         c0;
        logic [W:0]   full;
        logic [W-1:0] low;
        bb   = sub ? ~b : b;
        c0   = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
        low  = {1'b0, a[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, c0};
        return {full[W], low[W-1] ^ full[W], full[W-1:0]};
    endfunction

    task automatic scramble();
        a_i   = 8'($urandom);
        b_i   = 8'($urandom);
        sub_i = 1'($urandom);
        cin_i = 1'($urandom);
    endtask

    // Issue one operation and check latency (edges from acceptance to done) and results.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic c, input logic [W-1:0] es, input logic ec,
                          input logic eo, input string nm);
        int n;
        int lat;
        n = 0;
        while (!in_ready_o && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        a_i = a; b_i = b; sub_i = s; cin_i = c; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        scramble();
        lat = 0;
        while (!done_o && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        chk({nm, "_latency"}, lat, W);
        chk({nm, "_sum"}, sum_o, es);
        chk({nm, "_cout"}, cout_o, ec);
        chk({nm, "_ovf"}, ovf_o, eo);
        @(negedge clk_i);
    endtask

    initial begin
        int n_done;
        int prev_done;
        int stable_bad;
        int n_push;
        int n_pop;
        bit have;
        logic [W-1:0] last_sum;
        logic [W+1:0] q[$];
        logic [W+1:0] e;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h55, 8'hAA, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[9] = '{8'h7F, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};

        rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; sub_i = 1'b0; cin_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_sum", sum_o, 0);
        chk("rst_cout", cout_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_in_ready", in_ready_o, 1);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
                   vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf,
                   $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_done_cleared", i), done_o, 0);
            chk($sformatf("vec%0d_ready_back", i), in_ready_o, 1);
        end

        // Second start during RUN must be ignored.
        a_i = 8'h5A; b_i = 8'h3C; sub_i = 1'b0; cin_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("ign_busy", busy_o, 1);
        chk("ign_in_ready", in_ready_o, 0);
        chk("ign_sum_held", sum_o, 8'h80);
        repeat (2) @(negedge clk_i);
        a_i = 8'h01; b_i = 8'h01; sub_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        n_done = 0;
        last_sum = '0;
        for (int k = 0; k < 16; k++) begin
            if (done_o) begin
                n_done++;
                last_sum = sum_o;
            end
            @(negedge clk_i);
        end
        chk("ign_done_count", n_done, 1);
        chk("ign_sum", last_sum, 8'h96);
        chk("ign_ovf", ovf_o, 1);

        // Asynchronous reset in the 4th RUN cycle.
        a_i = 8'hFF; b_i = 8'h01; sub_i = 1'b0; cin_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("midrst_sum", sum_o, 0);
        chk("midrst_cout", cout_o, 0);
        chk("midrst_ovf", ovf_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_in_ready", in_ready_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            if (done_o) n_done++;
            @(negedge clk_i);
        end
        chk("midrst_no_done", n_done, 0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "post_rst");

        // Start held high with random operands against the arithmetic model.
        prev_done = -1; stable_bad = 0; n_push = 0; n_pop = 0; have = 0;
        for (int cyc = 0; cyc < 70; cyc++) begin
            @(negedge clk_i);
            if (done_o) begin
                if (q.size() == 0) begin
                    chk("stream_unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    n_pop++;
                    chk($sformatf("stream%0d_sum", n_pop), sum_o, e[W-1:0]);
                    chk($sformatf("stream%0d_cout", n_pop), cout_o, e[W+1]);
                    chk($sformatf("stream%0d_ovf", n_pop), ovf_o, e[W]);
                end
                if (prev_done >= 0) chk($sformatf("stream%0d_interval", n_pop), cyc - prev_done, W + 2);
                prev_done = cyc;
                last_sum = sum_o;
                have = 1;
            end else if (have && sum_o !== last_sum) begin
                stable_bad++;
            end
            if (cyc < 40) begin
                start_i = 1'b1;
                scramble();
                if (in_ready_o) begin
                    q.push_back(model(a_i, b_i, sub_i, cin_i));
                    n_push++;
                end
            end else begin
                start_i = 1'b0;
            end
        end
        chk("stream_sum_stable", stable_bad, 0);
        chk("stream_all_done", n_pop, n_push);
        chk("stream_accept_count", n_push, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
